ex_mem_pipe_buf: RTL and testbench

Parametrised EX→MEM pipeline buffer that carries the execute-stage result bundle: write-back/memory-read/memory-write enables, destination and source register tags, ALU result and store value. It replaces the single-entry freeze-only register with a DEPTH-entry elastic buffer. The buffer adds a valid/ready handshake, a synchronous flush for branch/exception squash, and an occupancy count. It sits between the EX stage and the MEM stage; the hazard and forwarding units read its head-entry tags.

---
 rtl/ex_mem_pkg.sv | 24 ++
 rtl/ex_mem_buf_ctrl.sv | 77 +++++++
 rtl/ex_mem_pipe_buf.sv | 105 ++++++++++
 tb/tb_ex_mem_pipe_buf.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and sizing helpers for the EX->MEM pipeline buffer.
// The bundle layout here fixes the field order used when packing entries.
package ex_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 4;

    // Field order, MSB first, matches the flat entry vector in the buffer top.
    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic [REG_W_DEF-1:0]  dest;
        logic [REG_W_DEF-1:0]  src1;
        logic [REG_W_DEF-1:0]  src2;
        logic [DATA_W_DEF-1:0] alu_result;
        logic [DATA_W_DEF-1:0] st_val;
    } ex_mem_bundle_t;

    function automatic int bundle_width(input int data_w, input int reg_w);
        return 3 + 3 * reg_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/ex_mem_buf_ctrl.sv
// Pointer, occupancy and handshake control for the EX->MEM elastic buffer.
// Storage lives in the parent; this block only decides when to write and where the head is.
module ex_mem_buf_ctrl
    import ex_mem_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             push,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // in_ready looks only at local state, so no combinational path from out_ready.
    assign in_ready  = (count_q < CNT_FULL) & ~freeze;
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~freeze & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (!freeze) begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/ex_mem_pipe_buf.sv
// EX->MEM pipeline buffer: DEPTH-entry elastic FIFO carrying the execute result bundle.
// Control outputs are masked when empty so MEM sees a clean bubble.
module ex_mem_pipe_buf
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic [REG_W-1:0]  src1_in,
    input  logic [REG_W-1:0]  src2_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] st_val_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [REG_W-1:0]  dest_out,
    output logic [REG_W-1:0]  src1_out,
    output logic [REG_W-1:0]  src2_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] st_val_out,
    output logic [CNT_W-1:0]  count
);

    localparam int BUNDLE_W = bundle_width(DATA_W, REG_W);
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                push;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [BUNDLE_W-1:0] wr_bundle;
    logic [BUNDLE_W-1:0] head_bundle;
    logic [BUNDLE_W-1:0] entry_sel [DEPTH];
    logic                head_wb_en;
    logic                head_mem_r_en;
    logic                head_mem_w_en;

    assign wr_bundle = {wb_en_in, mem_r_en_in, mem_w_en_in,
                        dest_in, src1_in, src2_in,
                        alu_result_in, st_val_in};

    ex_mem_buf_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .push      (push),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // Entries are cleared on reset so the head reads all-zero straight out of reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [BUNDLE_W-1:0] entry_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry_q <= '0;
            end else if (push && (wr_ptr == PTR_W'(gi))) begin
                entry_q <= wr_bundle;
            end
        end

        assign entry_sel[gi] = (rd_ptr == PTR_W'(gi)) ? entry_q : '0;
    end

    // One-hot AND-OR read mux; avoids indexing past DEPTH for non-power-of-two depths.
    always_comb begin
        head_bundle = '0;
        for (int i = 0; i < DEPTH; i++) begin
            head_bundle = head_bundle | entry_sel[i];
        end
    end

    assign {head_wb_en, head_mem_r_en, head_mem_w_en,
            dest_out, src1_out, src2_out,
            alu_result_out, st_val_out} = head_bundle;

    assign wb_en_out    = head_wb_en    & out_valid;
    assign mem_r_en_out = head_mem_r_en & out_valid;
    assign mem_w_en_out = head_mem_w_en & out_valid;

endmodule

// File: tb/tb_ex_mem_pipe_buf.sv
// Bench for ex_mem_pipe_buf: DEPTH=2 and DEPTH=3 instances share stimulus and are
// compared every cycle against a queue model, plus table and directed sequences.
module tb_ex_mem_pipe_buf;
    import ex_mem_pkg::*;

    localparam int DW = 32;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic freeze = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    ex_mem_bundle_t in_b = '0;

    logic [1:0]    ir, ov, wb_o, mr_o, mw_o;
    logic [RW-1:0] dest_o [2];
    logic [RW-1:0] src1_o [2];
    logic [RW-1:0] src2_o [2];
    logic [DW-1:0] alu_o  [2];
    logic [DW-1:0] st_o   [2];
    logic [1:0]    cnt_o  [2];

    always #5 clk = ~clk;

    // Instance 0 has DEPTH=2, instance 1 has DEPTH=3.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ex_mem_pipe_buf #(.DATA_W(DW), .REG_W(RW), .DEPTH(gi + 2)) dut (
            .clk            (clk),
            .rst            (rst),
            .freeze         (freeze),
            .flush          (flush),
            .in_valid       (in_valid),
            .in_ready       (ir[gi]),
            .wb_en_in       (in_b.wb_en),
            .mem_r_en_in    (in_b.mem_r_en),
            .mem_w_en_in    (in_b.mem_w_en),
            .dest_in        (in_b.dest),
            .src1_in        (in_b.src1),
            .src2_in        (in_b.src2),
            .alu_result_in  (in_b.alu_result),
            .st_val_in      (in_b.st_val),
            .out_valid      (ov[gi]),
            .out_ready      (out_ready),
            .wb_en_out      (wb_o[gi]),
            .mem_r_en_out   (mr_o[gi]),
            .mem_w_en_out   (mw_o[gi]),
            .dest_out       (dest_o[gi]),
            .src1_out       (src1_o[gi]),
            .src2_out       (src2_o[gi]),
            .alu_result_out (alu_o[gi]),
            .st_val_out     (st_o[gi]),
            .count          (cnt_o[gi])
        );
    end

    typedef struct {
        bit          iv;
        bit          ordy;
        logic [31:0] alu;
        bit          e_ir;
        bit          e_ov;
        int          e_cnt;
        logic [31:0] e_alu;
    } vec_t;

    vec_t           tbl [15];
    ex_mem_bundle_t mq0 [$];
    ex_mem_bundle_t mq1 [$];
    logic [31:0]    rx [$];
    bit             rec = 1'b0;
    bit             last_ir [2];
    int             max_cnt3 = 0;
    int             n_checks = 0;
    int             n_fail = 0;

    function automatic vec_t mk(bit iv, bit ordy, logic [31:0] alu, bit eir, bit eov,
                                int ecnt, logic [31:0] ealu);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.alu = alu;
        v.e_ir = eir; v.e_ov = eov; v.e_cnt = ecnt; v.e_alu = ealu;
        return v;
    endfunction

    function automatic int msize(int d);
        return (d == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic ex_mem_bundle_t mhead(int d);
        if (msize(d) == 0) return '0;
        return (d == 0) ? mq0[0] : mq1[0];
    endfunction

    task automatic mupdate(input int d, input bit pu, input bit po);
        if (d == 0) begin
            if (po) void'(mq0.pop_front());
            if (pu) mq0.push_back(in_b);
        end else begin
            if (po) void'(mq1.pop_front());
            if (pu) mq1.push_back(in_b);
        end
    endtask

    task automatic mclear();
        mq0.delete();
        mq1.delete();
    endtask

    task automatic chk(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (depth %0d): got %0h, expected %0h", name, d + 2, act, exp);
        end
    endtask

    task automatic check_outputs(input int d);
        int sz;
        ex_mem_bundle_t h;
        sz = msize(d);
        h  = mhead(d);
        chk("count", d, 64'(cnt_o[d]), 64'(sz));
        chk("out_valid", d, 64'(ov[d]), 64'(sz != 0));
        chk("wb_en_out", d, 64'(wb_o[d]), 64'(sz != 0 && h.wb_en));
        chk("mem_r_en_out", d, 64'(mr_o[d]), 64'(sz != 0 && h.mem_r_en));
        chk("mem_w_en_out", d, 64'(mw_o[d]), 64'(sz != 0 && h.mem_w_en));
        if (sz != 0) begin
            chk("dest_out", d, 64'(dest_o[d]), 64'(h.dest));
            chk("src1_out", d, 64'(src1_o[d]), 64'(h.src1));
            chk("src2_out", d, 64'(src2_o[d]), 64'(h.src2));
            chk("alu_result_out", d, 64'(alu_o[d]), 64'(h.alu_result));
            chk("st_val_out", d, 64'(st_o[d]), 64'(h.st_val));
        end
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after.
    task automatic step();
        bit pu [2];
        bit po [2];
        int sz;
        #1;
        for (int d = 0; d < 2; d++) begin
            sz = msize(d);
            last_ir[d] = ir[d];
            chk("in_ready", d, 64'(ir[d]), 64'(sz < d + 2 && !freeze));
            pu[d] = in_valid && (sz < d + 2) && !freeze && !flush;
            po[d] = (sz != 0) && out_ready && !freeze && !flush;
        end
        if (rec && ov[1] && out_ready && !freeze && !flush) rx.push_back(alu_o[1]);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (flush) begin
                if (d == 0) mq0.delete(); else mq1.delete();
            end else begin
                mupdate(d, pu[d], po[d]);
            end
            check_outputs(d);
        end
        if (int'(cnt_o[1]) > max_cnt3) max_cnt3 = int'(cnt_o[1]);
    endtask

    task automatic set_in(input logic [31:0] alu);
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        in_b = r[$bits(ex_mem_bundle_t)-1:0];
        in_b.alu_result = alu;
    endtask

    // Asynchronous reset raised between edges; outputs must clear before any edge.
    task automatic reset_check();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        mclear();
        for (int d = 0; d < 2; d++) begin
            chk("rst_count", d, 64'(cnt_o[d]), 64'(0));
            chk("rst_out_valid", d, 64'(ov[d]), 64'(0));
            chk("rst_ctrl", d, 64'({wb_o[d], mr_o[d], mw_o[d]}), 64'(0));
            chk("rst_tags", d, 64'({dest_o[d], src1_o[d], src2_o[d]}), 64'(0));
            chk("rst_alu", d, 64'(alu_o[d]), 64'(0));
            chk("rst_st_val", d, 64'(st_o[d]), 64'(0));
            chk("rst_in_ready", d, 64'(ir[d]), 64'(1));
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic flush_all();
        flush = 1'b1;
        in_valid = 1'b0;
        step();
        flush = 1'b0;
    endtask

    initial begin
        int sent;
        bit done;

        for (int k = 0; k < 8; k++) begin
            tbl[k] = mk(1, 1, 32'hA0 + 32'(k), 1, 1, 1, 32'hA0 + 32'(k));
        end
        tbl[8]  = mk(0, 1, 32'h00, 1, 0, 0, 32'h00);
        tbl[9]  = mk(1, 0, 32'h01, 1, 1, 1, 32'h01);
        tbl[10] = mk(1, 0, 32'h02, 1, 1, 2, 32'h01);
        tbl[11] = mk(1, 0, 32'h03, 0, 1, 2, 32'h01);
        tbl[12] = mk(1, 1, 32'h03, 0, 1, 1, 32'h02);
        tbl[13] = mk(1, 1, 32'h03, 1, 1, 1, 32'h03);
        tbl[14] = mk(0, 1, 32'h00, 1, 0, 0, 32'h00);

        @(posedge clk);
        #1;
        reset_check();

        // Streaming and backpressure on DEPTH=2.
        for (int i = 0; i < 15; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            set_in(tbl[i].alu);
            step();
            chk("tbl_in_ready", 0, 64'(last_ir[0]), 64'(tbl[i].e_ir));
            chk("tbl_count", 0, 64'(cnt_o[0]), 64'(tbl[i].e_cnt));
            chk("tbl_out_valid", 0, 64'(ov[0]), 64'(tbl[i].e_ov));
            if (tbl[i].e_ov) chk("tbl_alu_out", 0, 64'(alu_o[0]), 64'(tbl[i].e_alu));
        end
        flush_all();

        // Freeze holding one entry.
        in_valid = 1'b1; out_ready = 1'b0;
        set_in(32'h55); in_b.dest = 4'd5; in_b.mem_w_en = 1'b1;
        step();
        freeze = 1'b1; out_ready = 1'b1;
        set_in(32'h66); in_b.dest = 4'd6;
        repeat (3) begin
            step();
            chk("frz_in_ready", 0, 64'(last_ir[0]), 64'(0));
            chk("frz_count", 0, 64'(cnt_o[0]), 64'(1));
            chk("frz_dest", 0, 64'(dest_o[0]), 64'(5));
            chk("frz_mem_w_en", 0, 64'(mw_o[0]), 64'(1));
        end
        freeze = 1'b0;
        step();
        chk("unfrz_alu", 0, 64'(alu_o[0]), 64'(32'h66));
        chk("unfrz_dest", 0, 64'(dest_o[0]), 64'(6));
        in_valid = 1'b0;
        step();

        // Flush with a simultaneous push.
        in_valid = 1'b1; out_ready = 1'b0;
        set_in(32'hB1); step();
        set_in(32'hB2); step();
        chk("pre_flush_count", 0, 64'(cnt_o[0]), 64'(2));
        flush = 1'b1;
        set_in(32'hFF); in_b.wb_en = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_count", 0, 64'(cnt_o[0]), 64'(0));
        chk("flush_ctrl", 0, 64'({wb_o[0], mr_o[0], mw_o[0]}), 64'(0));
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) begin
            step();
            chk("flush_ff_seen", 0, 64'(ov[0] && alu_o[0] == 32'hFF), 64'(0));
        end

        // Wrap-around on DEPTH=3 with alternating out_ready.
        flush_all();
        rx.delete(); rec = 1'b1; max_cnt3 = 0; sent = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            in_valid  = (sent < 10);
            out_ready = c[0];
            set_in(32'hC0 + 32'(sent));
            step();
            if (in_valid && last_ir[1]) sent++;
            done = (sent == 10) && (cnt_o[1] == 2'd0);
        end
        rec = 1'b0;
        chk("wrap_done", 1, 64'(done), 64'(1));
        chk("wrap_rx_count", 1, 64'(rx.size()), 64'(10));
        for (int i = 0; i < 10 && i < rx.size(); i++) begin
            chk("wrap_order", 1, 64'(rx[i]), 64'(32'hC0 + 32'(i)));
        end
        chk("wrap_max_count_ok", 1, 64'(max_cnt3 <= 3), 64'(1));

        // Randomised traffic against the queue model.
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1) != 0;
            freeze    = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            set_in($urandom);
            step();
        end
        freeze = 1'b0; flush = 1'b0;

        // Reset in the middle of a stream.
        flush_all();
        in_valid = 1'b1; out_ready = 1'b0;
        set_in(32'h11); in_b.wb_en = 1'b1; step();
        set_in(32'h22); in_b.wb_en = 1'b1; step();
        chk("pre_rst_count", 0, 64'(cnt_o[0]), 64'(2));
        reset_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
